// File: rtl/ball_bounce_engine_pkg.sv
// Shared types and constants for the bouncing-ball engine: FSM state encoding,
// bounce counter width and the signed-velocity working width.
package ball_bounce_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVE   = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    localparam int unsigned COUNT_W = 8;

    // Position plus signed velocity needs one extra bit to detect both walls.
    function automatic int unsigned svel_w(input int unsigned w);
        return w + 1;
    endfunction

endpackage

// File: rtl/ball_bounce_engine_if.sv
// Control/status bus of the ball engine: launch/pause requests in,
// FSM state, bounce pulses, bounce count and live velocities out.
interface ball_bounce_engine_if
    import ball_bounce_engine_pkg::*;
#(
    parameter int unsigned WIDTH = 9
);
    logic               launch;
    logic [WIDTH-1:0]   launch_hvel;
    logic [WIDTH-1:0]   launch_vvel;
    logic               pause;
    logic [1:0]         state;
    logic               bounce_h;
    logic               bounce_v;
    logic [COUNT_W-1:0] bounce_count;
    logic [WIDTH-1:0]   hvel;
    logic [WIDTH-1:0]   vvel;

    modport master (
        output launch, launch_hvel, launch_vvel, pause,
        input  state, bounce_h, bounce_v, bounce_count, hvel, vvel
    );

    modport slave (
        input  launch, launch_hvel, launch_vvel, pause,
        output state, bounce_h, bounce_v, bounce_count, hvel, vvel
    );
endinterface

// File: rtl/ball_bounce_engine_axis.sv
// One motion axis: position/velocity registers with clamped reflection at 0 and LIM,
// plus a one-clk bounce pulse.
module ball_axis
    import ball_bounce_engine_pkg::*;
#(
    parameter int unsigned WIDTH    = 9,
    parameter int unsigned LIM      = 252,
    parameter int unsigned INIT     = 128,
    parameter int          VEL_INIT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_vel,
    output logic [WIDTH-1:0] pos,
    output logic [WIDTH-1:0] vel,
    output logic             bounce
);
    localparam int unsigned SW = svel_w(WIDTH);
    localparam logic signed [SW-1:0] LIM_S = SW'(LIM);

    logic signed [SW-1:0] nxt;

    always_comb begin
        nxt = $signed({1'b0, pos}) + $signed({vel[WIDTH-1], vel});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos    <= WIDTH'(INIT);
            vel    <= WIDTH'(VEL_INIT);
            bounce <= 1'b0;
        end else begin
            bounce <= 1'b0;
            if (load) begin
                pos <= WIDTH'(INIT);
                vel <= (load_vel == '0) ? WIDTH'(VEL_INIT) : load_vel;
            end else if (tick_en) begin
                if (nxt[SW-1]) begin
                    pos    <= '0;
                    vel    <= -vel;
                    bounce <= 1'b1;
                end else if (nxt > LIM_S) begin
                    pos    <= WIDTH'(LIM);
                    vel    <= -vel;
                    bounce <= 1'b1;
                end else begin
                    pos <= nxt[WIDTH-1:0];
                end
            end
        end
    end
endmodule

// File: rtl/ball_bounce_engine.sv
// Single-ball motion and render engine: vsync-derived frame tick, IDLE/MOVE/PAUSED FSM,
// two clamped axes, saturating bounce counter and a registered ball pixel.
module ball_bounce_engine
    import ball_bounce_engine_pkg::*;
#(
    parameter int unsigned WIDTH      = 9,
    parameter int unsigned BALL_SIZE  = 4,
    parameter int unsigned H_LIMIT    = 256,
    parameter int unsigned V_LIMIT    = 240,
    parameter int unsigned H_INIT     = 128,
    parameter int unsigned V_INIT     = 128,
    parameter int          H_VEL_INIT = 2,
    parameter int          V_VEL_INIT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 vsync,
    input  logic                 display_on,
    input  logic [WIDTH-1:0]     hpos,
    input  logic [WIDTH-1:0]     vpos,
    ball_bounce_engine_if.slave  ctrl,
    output logic [WIDTH-1:0]     ball_hpos,
    output logic [WIDTH-1:0]     ball_vpos,
    output logic                 ball_gfx
);
    state_t state_q, state_d;
    logic   vsync_q, tick, tick_en, load;
    logic [WIDTH-1:0] dx, dy;

    // vsync_q resets high so a vsync already high at reset release is not a tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) vsync_q <= 1'b1;
        else       vsync_q <= vsync;
    end
    assign tick = vsync & ~vsync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // A pause change in the tick clk blocks the update: tick_en only in steady MOVE.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        tick_en = 1'b0;
        case (state_q)
            ST_IDLE:   if (ctrl.launch) begin
                           state_d = ST_MOVE;
                           load    = 1'b1;
                       end
            ST_MOVE:   if (ctrl.pause) state_d = ST_PAUSED;
                       else            tick_en = tick;
            ST_PAUSED: if (!ctrl.pause) state_d = ST_MOVE;
            default:   state_d = ST_IDLE;
        endcase
    end
    assign ctrl.state = state_q;

    ball_axis #(
        .WIDTH(WIDTH), .LIM(H_LIMIT - BALL_SIZE), .INIT(H_INIT), .VEL_INIT(H_VEL_INIT)
    ) u_axis_h (
        .clk(clk), .reset(reset), .tick_en(tick_en), .load(load),
        .load_vel(ctrl.launch_hvel), .pos(ball_hpos), .vel(ctrl.hvel), .bounce(ctrl.bounce_h)
    );

    ball_axis #(
        .WIDTH(WIDTH), .LIM(V_LIMIT - BALL_SIZE), .INIT(V_INIT), .VEL_INIT(V_VEL_INIT)
    ) u_axis_v (
        .clk(clk), .reset(reset), .tick_en(tick_en), .load(load),
        .load_vel(ctrl.launch_vvel), .pos(ball_vpos), .vel(ctrl.vvel), .bounce(ctrl.bounce_v)
    );

    // Counts the registered pulse, so the count settles one clk after the bounce.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ctrl.bounce_count <= '0;
        else if ((ctrl.bounce_h || ctrl.bounce_v) && (ctrl.bounce_count != '1))
            ctrl.bounce_count <= ctrl.bounce_count + 1'b1;
    end

    always_comb begin
        dx = hpos - ball_hpos;
        dy = vpos - ball_vpos;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ball_gfx <= 1'b0;
        else       ball_gfx <= display_on && (dx < WIDTH'(BALL_SIZE)) && (dy < WIDTH'(BALL_SIZE));
    end
endmodule
